// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ctrl
//  Description : IF-stage sequencer owning the fetch PC and the imem
//                request/ack handshake, with stall, flush and skid support.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    input  logic        prdt_taken_i,
    input  logic [31:0] prdt_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o,
    output logic        stallreq_o
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] redir_pc_q, redir_pc_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_inst_q, skid_inst_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        valid_q, valid_d;

    logic [31:0] w_next_pc;
    logic [31:0] w_flush_pc;

    assign w_flush_pc = {flush_pc_i[31:2], 2'b00};
    assign w_next_pc  = prdt_taken_i ? {prdt_target_i[31:2], 2'b00}
                                     : (fetch_pc_q + 32'd4);

    assign imem_req_o   = (state_q == S_FETCH) || (state_q == S_DRAIN);
    assign imem_addr_o  = fetch_pc_q;
    assign stallreq_o   = imem_req_o & ~imem_ack_i;
    assign pc_o         = pc_q;
    assign inst_o       = inst_q;
    assign inst_valid_o = valid_q;

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        redir_pc_d  = redir_pc_q;
        skid_pc_d   = skid_pc_q;
        skid_inst_d = skid_inst_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        valid_d     = valid_q;

        // A flush empties the IF/ID boundary and the skid regardless of state.
        if (flush_i) begin
            pc_d        = 32'd0;
            inst_d      = 32'd0;
            valid_d     = 1'b0;
            skid_pc_d   = 32'd0;
            skid_inst_d = 32'd0;
        end

        case (state_q)
            S_BOOT: begin
                state_d = S_FETCH;
                if (flush_i) fetch_pc_d = w_flush_pc;
            end
            S_FETCH: begin
                if (flush_i) begin
                    if (imem_ack_i) begin
                        fetch_pc_d = w_flush_pc;
                    end else begin
                        redir_pc_d = w_flush_pc;
                        state_d    = S_DRAIN;
                    end
                end else if (imem_ack_i) begin
                    fetch_pc_d = w_next_pc;
                    if (stall_i) begin
                        skid_pc_d   = fetch_pc_q;
                        skid_inst_d = imem_rdata_i;
                        state_d     = S_HOLD;
                    end else begin
                        pc_d    = fetch_pc_q;
                        inst_d  = imem_rdata_i;
                        valid_d = 1'b1;
                    end
                end else if (!stall_i) begin
                    pc_d    = 32'd0;
                    inst_d  = 32'd0;
                    valid_d = 1'b0;
                end
            end
            S_HOLD: begin
                if (flush_i) begin
                    fetch_pc_d = w_flush_pc;
                    state_d    = S_FETCH;
                end else if (!stall_i) begin
                    pc_d    = skid_pc_q;
                    inst_d  = skid_inst_q;
                    valid_d = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_DRAIN: begin
                // The old address stays on the bus; the redirect waits in redir_pc.
                if (imem_ack_i) begin
                    fetch_pc_d = flush_i ? w_flush_pc : redir_pc_q;
                    state_d    = S_FETCH;
                end else if (flush_i) begin
                    redir_pc_d = w_flush_pc;
                end
            end
            default: state_d = S_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_BOOT;
            fetch_pc_q  <= {RESET_PC[31:2], 2'b00};
            redir_pc_q  <= 32'd0;
            skid_pc_q   <= 32'd0;
            skid_inst_q <= 32'd0;
            pc_q        <= 32'd0;
            inst_q      <= 32'd0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            redir_pc_q  <= redir_pc_d;
            skid_pc_q   <= skid_pc_d;
            skid_inst_q <= skid_inst_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            valid_q     <= valid_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_ctrl
//  Description : Randomized scoreboard bench for fetch_ctrl with an
//                instruction-stream reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        flush_i;
    logic [31:0] flush_pc_i;
    logic        prdt_taken_i;
    logic [31:0] prdt_target_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;
    logic        stallreq_o;

    always #5 clk = ~clk;

    fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .flush_pc_i   (flush_pc_i),
        .prdt_taken_i (prdt_taken_i),
        .prdt_target_i(prdt_target_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ack_i   (imem_ack_i),
        .imem_rdata_i (imem_rdata_i),
        .pc_o         (pc_o),
        .inst_o       (inst_o),
        .inst_valid_o (inst_valid_o),
        .stallreq_o   (stallreq_o)
    );

    // Memory contents and predictor behaviour are pure functions of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    function automatic logic pred_taken(input logic [31:0] a);
        return a[5:2] == 4'b1011;
    endfunction

    function automatic logic [31:0] pred_target(input logic [31:0] a);
        return (a - 32'h40) | {30'd0, a[9:8]};
    endfunction

    assign imem_rdata_i  = mem_word(imem_addr_o);
    assign prdt_taken_i  = pred_taken(imem_addr_o);
    assign prdt_target_i = pred_target(imem_addr_o);

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    logic [31:0] exp_fetch;
    logic        discard;
    logic        prev_ok, prev_rst, prev_req, prev_ack, prev_stall, prev_flush, prev_valid;
    logic        prev_hold_ack;
    logic [31:0] prev_addr, prev_pc, prev_inst;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    initial begin
        prev_ok = 1'b0; prev_rst = 1'b0; prev_req = 1'b0; prev_ack = 1'b0;
        prev_stall = 1'b0; prev_flush = 1'b0; prev_valid = 1'b0; prev_hold_ack = 1'b0;
        prev_addr = '0; prev_pc = '0; prev_inst = '0;
        exp_fetch = RESET_PC; discard = 1'b0;
    end

    // Monitor / scoreboard: samples mid-cycle, away from the active edge.
    always @(negedge clk) begin
        logic [63:0] e;
        logic        this_hold_ack;
        this_hold_ack = 1'b0;
        if (rst) begin
            exp_q.delete();
            exp_fetch = {RESET_PC[31:2], 2'b00};
            discard   = 1'b0;
        end else begin
            if (prev_rst) begin
                chk("reset_pc", pc_o, 32'd0);
                chk("reset_inst", inst_o, 32'd0);
                chk("reset_valid", {31'd0, inst_valid_o}, 32'd0);
                chk("reset_req", {31'd0, imem_req_o}, 32'd0);
                chk("reset_addr", imem_addr_o, {RESET_PC[31:2], 2'b00});
            end
            chk("stallreq", {31'd0, stallreq_o}, {31'd0, imem_req_o & ~imem_ack_i});
            if (!inst_valid_o) begin
                chk("bubble_pc", pc_o, 32'd0);
                chk("bubble_inst", inst_o, 32'd0);
            end
            if (prev_ok && prev_stall && !prev_flush) begin
                chk("hold_pc", pc_o, prev_pc);
                chk("hold_inst", inst_o, prev_inst);
                chk("hold_valid", {31'd0, inst_valid_o}, {31'd0, prev_valid});
            end
            if (prev_ok && prev_req && !prev_ack) begin
                chk("req_held", {31'd0, imem_req_o}, 32'd1);
                chk("addr_stable", imem_addr_o, prev_addr);
            end else if (imem_req_o && !discard) begin
                chk("req_addr", imem_addr_o, exp_fetch);
            end
            if (prev_ok && prev_hold_ack)
                chk("hold_no_req", {31'd0, imem_req_o}, 32'd0);

            // Delivery to ID: a valid output seen while ID is not stalled or flushed.
            if (inst_valid_o && !stall_i && !flush_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_inst actual_pc=%h required=none t=%0t", pc_o, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("id_pc", pc_o, e[63:32]);
                    chk("id_inst", inst_o, e[31:0]);
                end
            end

            if (imem_req_o && imem_ack_i) begin
                if (discard) begin
                    discard = 1'b0;
                end else if (!flush_i) begin
                    exp_q.push_back({exp_fetch, mem_word(exp_fetch)});
                    this_hold_ack = stall_i;
                    exp_fetch = pred_taken(exp_fetch) ? (pred_target(exp_fetch) & ~32'd3)
                                                      : (exp_fetch + 32'd4);
                end
            end
            if (flush_i) begin
                exp_q.delete();
                exp_fetch = flush_pc_i & ~32'd3;
                if (imem_req_o && !imem_ack_i) discard = 1'b1;
            end
        end
        prev_ok       = !rst;
        prev_rst      = rst;
        prev_req      = imem_req_o;
        prev_ack      = imem_ack_i;
        prev_stall    = stall_i;
        prev_flush    = flush_i;
        prev_valid    = inst_valid_o;
        prev_pc       = pc_o;
        prev_inst     = inst_o;
        prev_addr     = imem_addr_o;
        prev_hold_ack = this_hold_ack;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0; flush_pc_i = '0; imem_ack_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Zero-wait boot stream, then a redirect that exercises alignment and wrap.
        repeat (8) step();
        flush_i = 1'b1; flush_pc_i = 32'hFFFF_FFFE;
        step();
        flush_i = 1'b0;
        repeat (6) step();

        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 199) == 0);
            stall_i    = ($urandom_range(0, 3) == 0);
            imem_ack_i = ($urandom_range(0, 9) < 6);
            flush_i    = ($urandom_range(0, 24) == 0);
            case ($urandom_range(0, 3))
                0:       flush_pc_i = $urandom;
                1:       flush_pc_i = 32'hFFFF_FFF0 | ($urandom & 32'hF);
                2:       flush_pc_i = $urandom & 32'hFF;
                default: flush_pc_i = 32'hFFFF_FFFE;
            endcase
            step();
        end

        rst = 1'b0; stall_i = 1'b0; flush_i = 1'b0; imem_ack_i = 1'b0;
        repeat (6) step();
        @(negedge clk);
        #1;
        chk("final_queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
